// File: rtl/pit_pkg.sv
// Shared definitions for the PIT Wishbone master and slave.
// State encoding and PIT register map.
package pit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] PIT_CNTRL = 3'd0;
    localparam logic [2:0] PIT_MOD   = 3'd1;
    localparam logic [2:0] PIT_COUNT = 3'd2;

endpackage

// File: rtl/pit_wb_watchdog.sv
// Bus-cycle watchdog: clear/increment counter with terminal compare.
// expire fires on the clock that would bring the count to TIMEOUT.
module pit_wb_watchdog #(
    parameter int TIMEOUT  = 15,
    parameter int TO_WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam logic [TO_WIDTH-1:0] LAST = TO_WIDTH'(TIMEOUT - 1);

    logic [TO_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + TO_WIDTH'(1);
        end
    end

    assign expire = inc && (count == LAST);

endmodule

// File: rtl/pit_wb_master.sv
// Wishbone classic single-transfer master for the PIT register slave.
// Command/response front end, one outstanding transfer, watchdog abort.
module pit_wb_master
    import pit_pkg::*;
#(
    parameter int DWIDTH   = 16,
    parameter int TIMEOUT  = 15,
    parameter int TO_WIDTH = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [2:0]        cmd_adr,
    input  logic [DWIDTH-1:0] cmd_dat,
    input  logic [1:0]        cmd_sel,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_dat,
    output logic              rsp_err,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [2:0]        wb_adr_o,
    output logic [DWIDTH-1:0] wb_dat_o,
    output logic [1:0]        wb_sel_o,
    input  logic [DWIDTH-1:0] wb_dat_i,
    input  logic              wb_ack_i
);

    state_t state;
    state_t state_d;

    logic accept;
    logic in_bus;
    logic bus_ack;
    logic expire;

    assign accept  = cmd_valid && cmd_ready;
    assign in_bus  = (state == BUS);
    assign bus_ack = in_bus && wb_ack_i;

    pit_wb_watchdog #(
        .TIMEOUT  (TIMEOUT),
        .TO_WIDTH (TO_WIDTH)
    ) u_wdog (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (accept),
        .inc    (in_bus && !wb_ack_i),
        .expire (expire)
    );

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (accept) state_d = BUS;
            BUS:  if (wb_ack_i || expire) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake/strobe outputs are registered copies of the next state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
        end else begin
            state     <= state_d;
            cmd_ready <= (state_d == IDLE);
            rsp_valid <= (state_d == RESP);
            wb_cyc_o  <= (state_d == BUS);
            wb_stb_o  <= (state_d == BUS);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
            rsp_dat  <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                wb_we_o  <= cmd_we;
                wb_adr_o <= cmd_adr;
                wb_dat_o <= cmd_dat;
                wb_sel_o <= cmd_sel;
            end
            // An ack on the expiring clock still counts as a good transfer.
            if (bus_ack) begin
                rsp_dat <= wb_we_o ? '0 : wb_dat_i;
                rsp_err <= 1'b0;
            end else if (in_bus && expire) begin
                rsp_dat <= '0;
                rsp_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pit_wb_master.sv
// Randomised bench for pit_wb_master with a transaction-level model.
// Slave responses are scripted per transfer by wait-state count.
module tb_pit_wb_master;
    import pit_pkg::*;

    localparam int DW = 16;
    localparam int TO = 15;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          wb_rst_i;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [2:0]    cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [1:0]    cmd_sel;
    logic          rsp_valid;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [2:0]    wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [1:0]    wb_sel_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i;

    int n_checks = 0;
    int n_pass = 0;
    int bus_cycles = 0;
    int rsp_count = 0;
    int last_wait = 0;
    logic [DW-1:0] last_dat = '0;
    logic          last_err = 1'b0;

    pit_wb_master #(
        .DWIDTH   (DW),
        .TIMEOUT  (TO),
        .TO_WIDTH (TW)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i)
    );

    always #5 clk = ~clk;

    always @(posedge wb_stb_o) bus_cycles++;
    always @(posedge rsp_valid) rsp_count++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Runs one transfer; enters and leaves on a falling edge, leaving
    // the bench in the rsp_valid cycle. k >= TO means the slave never acks.
    task automatic xfer(input logic we, input logic [2:0] adr,
                        input logic [DW-1:0] dat, input logic [1:0] sel,
                        input int k, input logic [DW-1:0] rdata,
                        input bit hold, input string tag);
        int waited;
        int cnt;
        bit stable;
        int exp_cnt;
        bit exp_err;
        logic [DW-1:0] exp_dat;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        wb_dat_i  = rdata;
        waited = 0;
        while (!cmd_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        last_wait = waited;
        chk({tag, " accept"}, 32'(waited < 64), 1);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        cnt = 0;
        stable = 1'b1;
        while (wb_stb_o && cnt < 40) begin
            if (cnt == 0) begin
                chk({tag, " we"}, 32'(wb_we_o), 32'(we));
                chk({tag, " adr"}, 32'(wb_adr_o), 32'(adr));
                chk({tag, " dat_o"}, 32'(wb_dat_o), 32'(dat));
                chk({tag, " sel"}, 32'(wb_sel_o), 32'(sel));
            end
            stable &= wb_cyc_o && !cmd_ready && !rsp_valid &&
                      wb_we_o == we && wb_adr_o == adr &&
                      wb_dat_o == dat && wb_sel_o == sel;
            wb_ack_i = (cnt == k);
            cnt++;
            @(negedge clk);
        end
        wb_ack_i = 1'b0;
        exp_err = (k >= TO);
        exp_cnt = exp_err ? TO : k + 1;
        exp_dat = (we || exp_err) ? '0 : rdata;
        chk({tag, " stb_cycles"}, 32'(cnt), 32'(exp_cnt));
        chk({tag, " bus_stable"}, 32'(stable), 1);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 1);
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, " rsp_dat"}, 32'(rsp_dat), 32'(exp_dat));
        chk({tag, " cyc_low"}, 32'(wb_cyc_o), 0);
        chk({tag, " ready_low"}, 32'(cmd_ready), 0);
        last_dat = exp_dat;
        last_err = exp_err;
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk({tag, " rsp_pulse"}, 32'(rsp_valid), 0);
        chk({tag, " ready"}, 32'(cmd_ready), 1);
        chk({tag, " dat_hold"}, 32'(rsp_dat), 32'(last_dat));
        chk({tag, " err_hold"}, 32'(rsp_err), 32'(last_err));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int b0;
        int r0;
        logic [DW-1:0] rd;
        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        wb_dat_i  = '0;
        wb_ack_i  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst cmd_ready", 32'(cmd_ready), 1);
        chk("rst cyc", 32'(wb_cyc_o), 0);
        chk("rst stb", 32'(wb_stb_o), 0);
        chk("rst rsp_valid", 32'(rsp_valid), 0);
        chk("rst rsp_dat", 32'(rsp_dat), 0);
        chk("rst rsp_err", 32'(rsp_err), 0);
        chk("rst adr_dat", {13'd0, wb_adr_o, wb_dat_o}, 0);
        wb_rst_i = 1'b0;
        @(negedge clk);

        xfer(1'b1, PIT_MOD, 16'h00C8, 2'b11, 1, 16'hBEEF, 1'b0, "wr_mod");
        idle_chk("wr_mod");
        xfer(1'b0, PIT_CNTRL, 16'h0, 2'b11, 0, 16'h1234, 1'b0, "rd_cntrl");
        idle_chk("rd_cntrl");
        xfer(1'b0, PIT_COUNT, 16'h0, 2'b11, 1000, 16'h5A5A, 1'b0, "timeout");
        idle_chk("timeout");
        xfer(1'b0, PIT_COUNT, 16'h0, 2'b01, TO - 1, 16'h7E57, 1'b0, "ack_at_limit");
        idle_chk("ack_at_limit");

        b0 = bus_cycles;
        xfer(1'b1, PIT_MOD, 16'h0321, 2'b10, 2, 16'h0, 1'b1, "b2b_a");
        xfer(1'b0, PIT_MOD, 16'h0, 2'b11, 0, 16'hCAFE, 1'b0, "b2b_b");
        chk("b2b next_accept_wait", 32'(last_wait), 1);
        idle_chk("b2b");
        chk("b2b bus_cycles", 32'(bus_cycles - b0), 2);

        // Reset in the middle of a stalled bus cycle.
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = PIT_COUNT;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst stb_before", 32'(wb_stb_o), 1);
        r0 = rsp_count;
        wb_rst_i = 1'b1;
        @(negedge clk);
        chk("midrst cyc", 32'(wb_cyc_o), 0);
        chk("midrst stb", 32'(wb_stb_o), 0);
        wb_rst_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst no_rsp", 32'(rsp_count - r0), 0);
        chk("midrst ready", 32'(cmd_ready), 1);
        chk("midrst stb_after", 32'(wb_stb_o), 0);
        last_dat = '0;
        last_err = 1'b0;

        // Stray acknowledge while idle.
        b0 = bus_cycles;
        r0 = rsp_count;
        wb_ack_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        @(negedge clk);
        chk("stray stb", 32'(bus_cycles - b0), 0);
        chk("stray rsp", 32'(rsp_count - r0), 0);
        xfer(1'b0, PIT_CNTRL, 16'h0, 2'b11, 0, 16'h9A3C, 1'b0, "stray_rd");
        idle_chk("stray_rd");

        for (int i = 0; i < 40; i++) begin
            int k;
            k = ($urandom_range(0, 4) == 0) ? int'($urandom_range(12, 20))
                                            : int'($urandom_range(0, 3));
            rd = DW'($urandom);
            xfer(1'($urandom), 3'($urandom), DW'($urandom), 2'($urandom),
                 k, rd, 1'b0, "rand");
            idle_chk("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
